// File: rtl/bw_clk_cl_hdr_ctl.sv
// Cluster clock-header controller: turns clock on/off requests into a registered,
// glitch-free gating enable, with a stop-drain delay and a counted single-step burst.
// Optional scan override of the enable is built when BW_CLK_HDR_SCAN_EN is defined.
module bw_clk_cl_hdr_ctl #(
  parameter int STOP_DLY = 4,
  parameter int STEP_W   = 8
) (
  input  logic              gclk,
  input  logic              arst,
  input  logic              cken_req,
  output logic              cken_ack,
  input  logic              step_val,
  input  logic [STEP_W-1:0] step_cnt,
  output logic              step_rej,
  output logic              rclk_en,
  output logic              busy
`ifdef BW_CLK_HDR_SCAN_EN
  ,
  input  logic              se
`endif
);

  localparam int CNT_W = (STEP_W > 4) ? STEP_W : 4;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(STOP_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rclk_en_q, rclk_en_d;
  logic             cken_ack_q, cken_ack_d;
  logic             busy_q, busy_d;
  logic             step_rej_q, step_rej_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (cken_req) begin
          state_d = ST_RUN;
        end else if (step_val && (step_cnt != '0)) begin
          state_d = ST_STEP;
          cnt_d   = CNT_W'(step_cnt);
        end
      end
      ST_RUN: begin
        if (!cken_req) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        // A renewed request aborts the drain without ever dropping the enable.
        if (cken_req) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STEP: begin
        // Burst length is fixed at entry; the request level only picks the exit state.
        if (cnt_q == CNT_ONE) begin
          state_d = cken_req ? ST_RUN : ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so each is a clean flop.
  always_comb begin
    rclk_en_d  = (state_d != ST_OFF);
    cken_ack_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_DRAIN) || (state_d == ST_STEP);
    step_rej_d = step_val && ((state_q != ST_OFF) || cken_req || (step_cnt == '0));
  end

  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      rclk_en_q  <= 1'b0;
      cken_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      step_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rclk_en_q  <= rclk_en_d;
      cken_ack_q <= cken_ack_d;
      busy_q     <= busy_d;
      step_rej_q <= step_rej_d;
    end
  end

  assign cken_ack = cken_ack_q;
  assign busy     = busy_q;
  assign step_rej = step_rej_q;

`ifdef BW_CLK_HDR_SCAN_EN
  assign rclk_en = se | rclk_en_q;
`else
  assign rclk_en = rclk_en_q;
`endif

endmodule

// File: tb/tb_bw_clk_cl_hdr_ctl.sv
// Bench for bw_clk_cl_hdr_ctl: directed scenarios followed by random traffic, all
// checked each cycle against a remaining-cycles model of the clock header.
module tb_bw_clk_cl_hdr_ctl;

  localparam int STOP_DLY = 4;
  localparam int STEP_W   = 8;

  logic              gclk;
  logic              arst;
  logic              cken_req;
  logic              cken_ack;
  logic              step_val;
  logic [STEP_W-1:0] step_cnt;
  logic              step_rej;
  logic              rclk_en;
  logic              busy;
`ifdef BW_CLK_HDR_SCAN_EN
  logic              se;
`endif

  int n_assert;
  int n_fail;
  int en_cnt;
  int rej_cnt;

  // Model: clock granted flag, drain cycles left, step cycles left, pending reject.
  int m_run;
  int m_drain_left;
  int m_step_left;
  int m_rej;

  bw_clk_cl_hdr_ctl #(.STOP_DLY(STOP_DLY), .STEP_W(STEP_W)) dut (
    .gclk     (gclk),
    .arst     (arst),
    .cken_req (cken_req),
    .cken_ack (cken_ack),
    .step_val (step_val),
    .step_cnt (step_cnt),
    .step_rej (step_rej),
    .rclk_en  (rclk_en),
    .busy     (busy)
`ifdef BW_CLK_HDR_SCAN_EN
    ,
    .se       (se)
`endif
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run        = 0;
    m_drain_left = 0;
    m_step_left  = 0;
    m_rej        = 0;
  endtask

  task automatic model_edge(input logic req, input logic sv, input int sc);
    int active;
    active = m_run + m_drain_left + m_step_left;
    m_rej  = (sv && (active != 0 || req || sc == 0)) ? 1 : 0;
    if (m_step_left > 0) begin
      m_step_left--;
      if (m_step_left == 0 && req) m_run = 1;
    end else if (m_drain_left > 0) begin
      if (req) begin
        m_drain_left = 0;
        m_run        = 1;
      end else begin
        m_drain_left--;
      end
    end else if (m_run != 0) begin
      if (!req) begin
        m_run        = 0;
        m_drain_left = STOP_DLY;
      end
    end else if (req) begin
      m_run = 1;
    end else if (sv && sc != 0) begin
      m_step_left = sc;
    end
  endtask

  task automatic check_model(input string tag);
    logic e_en, e_ack, e_busy, e_rej;
    e_busy = (m_drain_left > 0) || (m_step_left > 0);
    e_en   = (m_run != 0) || e_busy;
    e_ack  = (m_run != 0);
    e_rej  = (m_rej != 0);
    chk({tag, ".rclk_en"},  rclk_en,  e_en);
    chk({tag, ".cken_ack"}, cken_ack, e_ack);
    chk({tag, ".busy"},     busy,     e_busy);
    chk({tag, ".step_rej"}, step_rej, e_rej);
    if (rclk_en === 1'b1) en_cnt++;
    if (step_rej === 1'b1) rej_cnt++;
  endtask

  // Called at a falling edge: drive inputs, take the rising edge, check at the next falling edge.
  task automatic cyc(input string tag, input logic req, input logic sv, input int sc);
    cken_req = req;
    step_val = sv;
    step_cnt = STEP_W'(sc);
    @(posedge gclk);
    model_edge(req, sv, sc);
    @(negedge gclk);
    check_model(tag);
  endtask

  initial begin
    int r_req;
    n_assert = 0;
    n_fail   = 0;
    en_cnt   = 0;
    rej_cnt  = 0;
    model_reset();
    arst     = 1'b1;
    cken_req = 1'b0;
    step_val = 1'b0;
    step_cnt = '0;
`ifdef BW_CLK_HDR_SCAN_EN
    se       = 1'b0;
`endif

    // Reset state
    #2;
    chk("reset.rclk_en",  rclk_en,  1'b0);
    chk("reset.cken_ack", cken_ack, 1'b0);
    chk("reset.busy",     busy,     1'b0);
    chk("reset.step_rej", step_rej, 1'b0);
    repeat (3) @(negedge gclk);
    arst = 1'b0;

    // Clock on after a few idle cycles
    repeat (4) cyc("idle", 1'b0, 1'b0, 0);
    cyc("on", 1'b1, 1'b0, 0);
    chk("on.en_direct",  rclk_en,  1'b1);
    chk("on.ack_direct", cken_ack, 1'b1);
    chk("on.busy_direct", busy,    1'b0);
    repeat (13) cyc("run", 1'b1, 1'b0, 0);

    // Stop: enable stays high for exactly STOP_DLY cycles
    en_cnt = 0;
    cyc("stop", 1'b0, 1'b0, 0);
    chk("stop.ack_drop", cken_ack, 1'b0);
    chk("stop.busy",     busy,     1'b1);
    repeat (STOP_DLY + 3) cyc("drain", 1'b0, 1'b0, 0);
    chk_int("stop.en_cycles", en_cnt, STOP_DLY);

    // Step burst of 3 with a rejected request mid-burst
    en_cnt  = 0;
    rej_cnt = 0;
    cyc("step3.go", 1'b0, 1'b1, 3);
    cyc("step3.mid", 1'b0, 1'b1, 7);
    chk("step3.rej_direct", step_rej, 1'b1);
    repeat (5) cyc("step3.tail", 1'b0, 1'b0, 0);
    chk_int("step3.en_cycles", en_cnt, 3);
    chk_int("step3.rej_pulses", rej_cnt, 1);

    // Drain abort in the second drain cycle: no gap in enable
    repeat (3) cyc("abort.run", 1'b1, 1'b0, 0);
    en_cnt = 0;
    cyc("abort.d1", 1'b0, 1'b0, 0);
    cyc("abort.d2", 1'b0, 1'b0, 0);
    cyc("abort.req", 1'b1, 1'b0, 0);
    chk("abort.ack_back", cken_ack, 1'b1);
    repeat (2) cyc("abort.hold", 1'b1, 1'b0, 0);
    chk_int("abort.no_gap", en_cnt, 5);
    repeat (STOP_DLY + 3) cyc("abort.off", 1'b0, 1'b0, 0);

    // Simultaneous request and step in OFF: request wins, step rejected
    cyc("simul", 1'b1, 1'b1, 5);
    chk("simul.ack", cken_ack, 1'b1);
    chk("simul.rej", step_rej, 1'b1);
    repeat (STOP_DLY + 3) cyc("simul.off", 1'b0, 1'b0, 0);

    // Zero-length step is rejected, enable stays off
    cyc("zero", 1'b0, 1'b1, 0);
    chk("zero.rej", step_rej, 1'b1);
    chk("zero.en",  rclk_en,  1'b0);
    cyc("zero.after", 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of a long burst
    cyc("long.go", 1'b0, 1'b1, 200);
    repeat (49) cyc("long.run", 1'b0, 1'b0, 0);
    #2;
    arst = 1'b1;
    #1;
    model_reset();
    chk("arst.rclk_en", rclk_en, 1'b0);
    chk("arst.busy",    busy,    1'b0);
    @(negedge gclk);
    arst   = 1'b0;
    en_cnt = 0;
    repeat (6) cyc("arst.off", 1'b0, 1'b0, 0);
    chk_int("arst.stays_off", en_cnt, 0);

`ifdef BW_CLK_HDR_SCAN_EN
    se = 1'b1;
    #1;
    chk("scan.en", rclk_en, 1'b1);
    chk("scan.busy", busy, 1'b0);
    se = 1'b0;
    #1;
    chk("scan.release", rclk_en, 1'b0);
    cyc("scan.after", 1'b0, 1'b0, 0);
`endif

    // Random traffic
    r_req = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) r_req = 1 - r_req;
      if ($urandom_range(0, 5) == 0)
        cyc("rand", r_req[0], 1'b1, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)));
      else
        cyc("rand", r_req[0], 1'b0, int'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
